// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_pkg
// Brief    : Shared core constants, write-back record type and rd decoder.
// Revision : 1.0
// ============================================================================
package wb_arbiter_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;
  localparam int NREGS = 1 << REG_W;

  typedef struct packed {
    logic             we;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_rec_t;

  // x0 is hard-wired, so it never shows up as a pending hazard.
  function automatic logic [NREGS-1:0] rd_onehot(input logic [REG_W-1:0] rd);
    logic [NREGS-1:0] m;
    m    = {{(NREGS-1){1'b0}}, 1'b1} << rd;
    m[0] = 1'b0;
    return m;
  endfunction

endpackage : wb_arbiter_pkg
`default_nettype wire

// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_if
// Brief    : ALU/LSU result inputs and register-file write-port bundle.
// Revision : 1.0
// ============================================================================
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN = wb_arbiter_pkg::XLEN
) ();

  logic             alu_valid;
  logic [REG_W-1:0] alu_rd;
  logic [XLEN-1:0]  alu_data;

  logic             lsu_valid;
  logic             lsu_ready;
  logic [REG_W-1:0] lsu_rd;
  logic [XLEN-1:0]  lsu_data;

  logic             rf_we;
  logic [REG_W-1:0] rf_rd;
  logic [XLEN-1:0]  rf_wdata;

  logic             stall_req;
  logic [NREGS-1:0] pending_mask;

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    output rf_we, rf_rd, rf_wdata,
    output stall_req, pending_mask
  );

  // Pipeline / memory side.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    input  rf_we, rf_rd, rf_wdata,
    input  stall_req, pending_mask
  );

endinterface : wb_arbiter_if
`default_nettype wire

// File: rtl/wb_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Brief    : Synchronous FIFO with head peek, count, and per-entry tag view.
// Revision : 1.0
// ============================================================================
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int WIDTH = 37,
  parameter int TAG_W = 5,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        full,
  output logic                        empty,
  output logic [DEPTH-1:0][TAG_W-1:0] entry_tag,
  output logic [DEPTH-1:0]            entry_valid
);

  localparam int c_aw = $clog2(DEPTH);

  logic [c_aw:0]                r_wr_ptr;
  logic [c_aw:0]                r_rd_ptr;
  logic [DEPTH-1:0][WIDTH-1:0]  r_mem;
  logic                         w_push;
  logic                         w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Payload needs no reset: entries are only observed through entry_valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[c_aw-1:0]] <= push_data;
  end

  assign head  = r_mem[r_rd_ptr[c_aw-1:0]];
  assign count = r_wr_ptr - r_rd_ptr;
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                 (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);

  // A slot is live when its distance from the read pointer is below count.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      logic [c_aw-1:0] w_off;
      assign w_off          = c_aw'(i) - r_rd_ptr[c_aw-1:0];
      assign entry_valid[i] = ({1'b0, w_off} < count);
      assign entry_tag[i]   = r_mem[i][TAG_W-1:0];
    end
  endgenerate

endmodule : wb_fifo
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Brief    : Register-file write-back arbiter, ALU priority over buffered LSU
//            results. Optional macro WB_BYPASS_EN: LSU result skips empty FIFO.
// Revision : 1.0
// ============================================================================
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN       = wb_arbiter_pkg::XLEN,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  wb_arbiter_if.slave  bus
);

  localparam int              c_aw         = $clog2(DEPTH);
  localparam int              c_fw         = XLEN + REG_W;
  localparam int              c_sw         = $clog2(STARVE_MAX + 1);
  localparam logic [c_sw-1:0] c_starve_max = c_sw'(STARVE_MAX);
  localparam logic [c_sw-1:0] c_starve_pre = c_sw'(STARVE_MAX - 1);

  logic                        w_full;
  logic                        w_empty;
  logic                        w_nonempty;
  logic                        w_lsu_fire;
  logic                        w_bypass;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_starved;
  logic [c_fw-1:0]             w_head;
  logic [REG_W-1:0]            w_head_rd;
  logic [XLEN-1:0]             w_head_data;
  logic [c_aw:0]               w_count;
  logic [DEPTH-1:0][REG_W-1:0] w_tags;
  logic [DEPTH-1:0]            w_tag_valid;

  logic                        w_nxt_we;
  logic [REG_W-1:0]            w_nxt_rd;
  logic [XLEN-1:0]             w_nxt_data;
  logic                        r_we;
  logic [REG_W-1:0]            r_rd;
  logic [XLEN-1:0]             r_wdata;

  logic [c_sw-1:0]             r_starve;
  logic                        r_stall;
  logic [NREGS-1:0]            w_mask;

  // Memory responses are never stalled, so acceptance ignores en.
  assign w_lsu_fire = bus.lsu_valid && !w_full;

`ifdef WB_BYPASS_EN
  assign w_bypass = en && w_empty && !bus.alu_valid && w_lsu_fire;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push      = w_lsu_fire && !w_bypass;
  assign w_nonempty  = (w_count != '0);
  assign w_pop       = en && !bus.alu_valid && w_nonempty;
  assign w_head_rd   = w_head[REG_W-1:0];
  assign w_head_data = w_head[c_fw-1:REG_W];

  wb_fifo #(
    .WIDTH (c_fw),
    .TAG_W (REG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (w_push),
    .push_data   ({bus.lsu_data, bus.lsu_rd}),
    .pop         (w_pop),
    .head        (w_head),
    .count       (w_count),
    .full        (w_full),
    .empty       (w_empty),
    .entry_tag   (w_tags),
    .entry_valid (w_tag_valid)
  );

  always_comb begin
    w_nxt_we   = r_we;
    w_nxt_rd   = r_rd;
    w_nxt_data = r_wdata;
    if (en) begin
      if (bus.alu_valid) begin
        w_nxt_we   = (bus.alu_rd != '0);
        w_nxt_rd   = bus.alu_rd;
        w_nxt_data = bus.alu_data;
      end else if (w_nonempty) begin
        w_nxt_we   = (w_head_rd != '0);
        w_nxt_rd   = w_head_rd;
        w_nxt_data = w_head_data;
      end else if (w_bypass) begin
        w_nxt_we   = (bus.lsu_rd != '0);
        w_nxt_rd   = bus.lsu_rd;
        w_nxt_data = bus.lsu_data;
      end else begin
        w_nxt_we   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_rd    <= '0;
      r_wdata <= '0;
    end else begin
      r_we    <= w_nxt_we;
      r_rd    <= w_nxt_rd;
      r_wdata <= w_nxt_data;
    end
  end

  assign w_starved = en && w_nonempty && !w_pop;

  // The counter saturates; stall rises on the same edge it reaches the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      if (w_empty || w_pop) begin
        r_starve <= '0;
      end else if (w_starved && (r_starve != c_starve_max)) begin
        r_starve <= r_starve + 1'b1;
      end

      if (w_pop) begin
        r_stall <= 1'b0;
      end else if (w_starved && (r_starve == c_starve_pre)) begin
        r_stall <= 1'b1;
      end
    end
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_tag_valid[i]) w_mask = w_mask | rd_onehot(w_tags[i]);
    end
    if (r_we) w_mask = w_mask | rd_onehot(r_rd);
  end

  assign bus.lsu_ready    = !w_full;
  assign bus.rf_we        = r_we;
  assign bus.rf_rd        = r_rd;
  assign bus.rf_wdata     = r_wdata;
  assign bus.stall_req    = r_stall;
  assign bus.pending_mask = w_mask;

endmodule : wb_arbiter
`default_nettype wire
